// File: rtl/y_sig_pkg.sv
// Shared types and constants for the y signature capture block.
package y_sig_pkg;

  // Window controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Default MISR feedback polynomial and window seed.
  localparam logic [31:0] DEF_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEF_SEED = 32'hFFFFFFFF;

  // Number of SIG_W-bit words needed to cover a Y_W-bit bus.
  function automatic int nwords(input int y_w, input int sig_w);
    return (y_w + sig_w - 1) / sig_w;
  endfunction

endpackage

// File: rtl/y_sig_fold.sv
// Combinational XOR fold of the wide y bus down to one SIG_W-bit word.
// The bus is zero-extended to a whole number of words before folding.
module y_sig_fold
  import y_sig_pkg::*;
#(
  parameter int Y_W   = 242,
  parameter int SIG_W = 32
) (
  input  logic [Y_W-1:0]   y,
  output logic [SIG_W-1:0] w
);

  localparam int NW    = nwords(Y_W, SIG_W);
  localparam int EXT_W = NW * SIG_W;

  logic [EXT_W-1:0] y_ext;
  logic [SIG_W-1:0] acc [NW+1];

  // Zero-extend y so every word slice is in range.
  always_comb begin
    y_ext          = '0;
    y_ext[Y_W-1:0] = y;
  end

  assign acc[0] = '0;

  generate
    for (genvar gi = 0; gi < NW; gi++) begin : g_fold
      assign acc[gi+1] = acc[gi] ^ y_ext[gi*SIG_W +: SIG_W];
    end
  endgenerate

  assign w = acc[NW];

endmodule

// File: rtl/y_sig_capture.sv
// Window-based MISR signature capture of the y observation bus.
// Optional feature macro: YSIG_COMPARE_EN adds exp_sig input and mismatch output.
module y_sig_capture
  import y_sig_pkg::*;
#(
  parameter int               Y_W     = 242,
  parameter int               SIG_W   = 32,
  parameter int               WIN_LEN = 64,
  parameter logic [SIG_W-1:0] POLY    = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED    = SIG_W'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [Y_W-1:0]   y,
  output logic             busy,
  output logic             sig_valid,
  input  logic             sig_ready,
  output logic [SIG_W-1:0] sig
`ifdef YSIG_COMPARE_EN
  ,
  input  logic [SIG_W-1:0] exp_sig,
  output logic             mismatch
`endif
);

  localparam int CNT_W = $clog2(WIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_LEN - 1);

  state_t           state_reg, state_next;
  logic [SIG_W-1:0] sig_reg, sig_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [SIG_W-1:0] w;
  logic [SIG_W-1:0] absorbed;
  logic             accept_start;

  y_sig_fold #(
    .Y_W   (Y_W),
    .SIG_W (SIG_W)
  ) u_fold (
    .y (y),
    .w (w)
  );

  // One MISR step: shift left, apply feedback when the MSB falls out, mix in the fold.
  always_comb begin
    absorbed = {sig_reg[SIG_W-2:0], 1'b0} ^ (sig_reg[SIG_W-1] ? POLY : '0) ^ w;
  end

  // Next-state logic for the window FSM, counter and signature register.
  always_comb begin
    state_next   = state_reg;
    sig_next     = sig_reg;
    cnt_next     = cnt_reg;
    accept_start = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_next   = RUN;
          sig_next     = SEED;
          cnt_next     = '0;
        end
      end
      RUN: begin
        // start is deliberately ignored while a window is absorbing.
        sig_next = absorbed;
        if (cnt_reg == CNT_LAST) begin
          // Counter stays at its last value so it can never wrap.
          state_next = HOLD;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      HOLD: begin
        // Signature is frozen until the consumer takes it; start alone is dropped.
        if (sig_ready) begin
          if (start) begin
            accept_start = 1'b1;
            state_next   = RUN;
            sig_next     = SEED;
            cnt_next     = '0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, counter and signature registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sig_reg   <= SEED;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sig_reg   <= sig_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign busy      = (state_reg == RUN);
  assign sig_valid = (state_reg == HOLD);
  assign sig       = sig_reg;

`ifdef YSIG_COMPARE_EN
  logic [SIG_W-1:0] exp_reg;

  // Capture the expected signature whenever a new window is opened.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_reg <= '0;
    end else if (accept_start) begin
      exp_reg <= exp_sig;
    end
  end

  assign mismatch = sig_valid && (sig_reg != exp_reg);
`else
  logic unused_accept;
  assign unused_accept = accept_start;
`endif

endmodule
